// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and widths for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int PC_W     = 30;
  localparam int STREAK_W = 4;   // holds MAX_DATA_STREAK up to 15
  localparam int TMO_W    = 8;   // holds TIMEOUT_CYCLES-1 up to 254

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FETCH = 2'd1,
    BUSY_DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/arb_priority_sel.sv
`default_nettype none
// ============================================================================
// Module   : arb_priority_sel
// Brief    : Combinational requester selection. Data (older instruction)
//            wins unless fetch has been starved for MAX_DATA_STREAK grants.
// Revision : 1.0 - initial release
// ============================================================================
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                i_fetch_req,
  input  logic                i_data_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_gnt_valid,
  output req_id_t             o_gnt_id
);

  localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic w_fetch_forced;

  assign w_fetch_forced = i_fetch_req && (i_streak == C_STREAK_MAX);

  // Pick a winner: data by default, fetch when data is idle or fetch is starved
  always_comb begin
    o_gnt_valid = i_fetch_req | i_data_req;
    o_gnt_id    = FETCH;
    if (i_data_req && !w_fetch_forced) begin
      o_gnt_id = DATA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the single memory port between instruction fetch and
//            data access; one access in flight, variable-latency handshake,
//            zero-bubble back-to-back grants and an access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clk_enable,
  input  logic              i_fetch_req,
  input  logic [PC_W-1:0]   i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic              o_fetch_valid,
  output logic [WORD_W-1:0] o_fetch_data,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [WORD_W-1:0] i_data_addr,
  input  logic [WORD_W-1:0] i_data_wdata,
  output logic              o_data_gnt,
  output logic              o_data_valid,
  output logic [WORD_W-1:0] o_data_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic              o_stall,
  output logic              o_bus_error
);

  localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [TMO_W-1:0]    C_TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [STREAK_W-1:0] r_streak;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [WORD_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                r_fetch_valid;
  logic                r_data_valid;
  logic [WORD_W-1:0]   r_fetch_data;
  logic [WORD_W-1:0]   r_data_rdata;
  logic                r_bus_error;

  logic                w_busy;
  logic                w_timeout;
  logic                w_complete;
  logic                w_slot_free;
  logic                w_sel_valid;
  req_id_t             w_sel_id;
  logic                w_fetch_gnt;
  logic                w_data_gnt;
  logic                w_any_gnt;
  logic [WORD_W-1:0]   w_done_data;

  arb_priority_sel #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_sel (
    .i_fetch_req (i_fetch_req),
    .i_data_req  (i_data_req),
    .i_streak    (r_streak),
    .o_gnt_valid (w_sel_valid),
    .o_gnt_id    (w_sel_id)
  );

  // An access ends either on mem_ready or when the wait limit is hit; a
  // ready on the limit cycle is a normal completion.
  assign w_busy      = (r_state != IDLE);
  assign w_timeout   = w_busy && !i_mem_ready && (r_tmo == C_TMO_LAST);
  assign w_complete  = w_busy && (i_mem_ready || w_timeout);
  assign w_slot_free = (r_state == IDLE) || w_complete;

  // Grants are only meaningful on enabled cycles, when the port can be reloaded
  assign w_fetch_gnt = i_clk_enable && w_slot_free && w_sel_valid && (w_sel_id == FETCH);
  assign w_data_gnt  = i_clk_enable && w_slot_free && w_sel_valid && (w_sel_id == DATA);
  assign w_any_gnt   = w_fetch_gnt | w_data_gnt;

  // Stores and aborted accesses return zero instead of bus data
  assign w_done_data = (w_timeout || r_mem_we) ? '0 : i_mem_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (i_clk_enable) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a new grant takes priority over returning to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_fetch_gnt) begin
      w_state_nxt = BUSY_FETCH;
    end else if (w_data_gnt) begin
      w_state_nxt = BUSY_DATA;
    end else if (w_complete) begin
      w_state_nxt = IDLE;
    end
  end

  // Memory port, response capture, timeout counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      r_fetch_data  <= '0;
      r_data_rdata  <= '0;
      r_bus_error   <= 1'b0;
      r_tmo         <= '0;
    end else if (i_clk_enable) begin
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      if (w_complete) begin
        if (r_state == BUSY_FETCH) begin
          r_fetch_valid <= 1'b1;
          r_fetch_data  <= w_done_data;
        end else begin
          r_data_valid  <= 1'b1;
          r_data_rdata  <= w_done_data;
        end
        if (w_timeout) begin
          r_bus_error <= 1'b1;
        end
      end
      if (w_any_gnt) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= w_fetch_gnt ? {i_fetch_addr, 2'b00} : i_data_addr;
        r_mem_we    <= w_data_gnt & i_data_we;
        r_mem_wdata <= w_data_gnt ? i_data_wdata : '0;
        r_tmo       <= '0;
      end else if (w_complete) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_tmo     <= '0;
      end else if (w_busy) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

  // Count data grants that bypass a waiting fetch; saturate at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (i_clk_enable) begin
      if (w_fetch_gnt) begin
        r_streak <= '0;
      end else if (w_data_gnt) begin
        if (!i_fetch_req) begin
          r_streak <= '0;
        end else if (r_streak != C_STREAK_MAX) begin
          r_streak <= r_streak + STREAK_W'(1);
        end
      end
    end
  end

  assign o_fetch_gnt   = w_fetch_gnt;
  assign o_data_gnt    = w_data_gnt;
  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_data  = r_fetch_data;
  assign o_data_valid  = r_data_valid;
  assign o_data_rdata  = r_data_rdata;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_bus_error   = r_bus_error;
  assign o_stall       = ((i_fetch_req | i_data_req) & ~w_any_gnt) | w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter with a transaction
//            level reference model and a latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_clk_enable, i_fetch_req, i_data_req, i_data_we, i_mem_ready;
  logic [29:0] i_fetch_addr;
  logic [31:0] i_data_addr, i_data_wdata, i_mem_rdata;
  logic        o_fetch_gnt, o_fetch_valid, o_data_gnt, o_data_valid;
  logic        o_mem_req, o_mem_we, o_stall, o_bus_error;
  logic [31:0] o_fetch_data, o_data_rdata, o_mem_addr, o_mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .i_clk_enable(i_clk_enable),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_gnt(o_fetch_gnt), .o_fetch_valid(o_fetch_valid), .o_fetch_data(o_fetch_data),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .o_data_gnt(o_data_gnt), .o_data_valid(o_data_valid),
    .o_data_rdata(o_data_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
    .i_mem_rdata(i_mem_rdata), .o_stall(o_stall), .o_bus_error(o_bus_error)
  );

  typedef struct { bit is_fetch; logic [31:0] addr; bit we; } acc_t;

  int   n_checks = 0;
  int   n_errors = 0;
  acc_t sb[$];
  int   log_g[$];   // observed grants: 1 = fetch, 2 = data
  int   log_v[$];   // observed valid pulses
  bit   m_busy;
  int   m_wait, m_lat, m_streak, lat_mode;
  logic e_mem_req, e_mem_we, e_fv, e_dv, e_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_fdata, e_drdata;
  int   f_todo, d_todo;
  bit   rand_addr, rand_en;
  int   ecount, obs_fg_e, obs_dg_e, obs_fv_e, obs_dv_e;
  logic [29:0] keep_faddr;

  // Memory image: a fixed word at 0x40, a hash elsewhere
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h40) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'hA5A51234;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_wait = 0; m_streak = 0; sb.delete();
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
    e_fdata = '0; e_drdata = '0; e_fv = 0; e_dv = 0; e_err = 0;
  endfunction

  task automatic next_fetch();
    i_fetch_req = (f_todo > 0);
    if (rand_addr) i_fetch_addr = 30'($urandom());
  endtask

  task automatic next_data();
    i_data_req = (d_todo > 0);
    if (rand_addr) begin
      i_data_addr  = $urandom();
      i_data_we    = 1'($urandom_range(0, 1));
      i_data_wdata = $urandom();
    end
  endtask

  function automatic void clear_obs();
    log_g.delete(); log_v.delete();
    obs_fg_e = -100; obs_dg_e = -100; obs_fv_e = -100; obs_dv_e = -100;
  endfunction

  // One clock: drive memory, check grants/stall, advance model, check port
  task automatic tick(input bit en);
    bit comp, tmo, free, fg, dg;
    logic [31:0] v;
    acc_t a;
    i_clk_enable = en;
    i_mem_ready  = (m_busy && m_wait == m_lat) || (!m_busy && ($urandom_range(0, 3) == 0));
    i_mem_rdata  = (m_busy && i_mem_ready) ? memfn(e_mem_addr) : $urandom();
    @(negedge clk);
    comp = m_busy && (i_mem_ready || m_wait == TMO - 1);
    tmo  = m_busy && !i_mem_ready && (m_wait == TMO - 1);
    free = !m_busy || comp;
    fg   = en && !rst && free && i_fetch_req && (!i_data_req || m_streak == MAXS);
    dg   = en && !rst && free && i_data_req && !fg;
    if (!rst) begin
      chk1("fetch_gnt", o_fetch_gnt, fg);
      chk1("data_gnt", o_data_gnt, dg);
      chk1("stall", o_stall, ((i_fetch_req || i_data_req) && !(fg || dg)) || m_busy);
      if (en && o_fetch_gnt) begin obs_fg_e = ecount + 1; log_g.push_back(1); end
      if (en && o_data_gnt)  begin obs_dg_e = ecount + 1; log_g.push_back(2); end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (en) begin
      ecount++;
      e_fv = 0; e_dv = 0;
      if (comp) begin
        a = sb.pop_front();
        v = (a.we || tmo) ? 32'h0 : memfn(a.addr);
        if (a.is_fetch) begin e_fv = 1; e_fdata = v; end
        else begin e_dv = 1; e_drdata = v; end
        if (tmo) e_err = 1;
      end
      if (fg || dg) begin
        a.is_fetch = fg;
        a.addr = fg ? {i_fetch_addr, 2'b00} : i_data_addr;
        a.we = dg && i_data_we;
        sb.push_back(a);
        e_mem_req = 1; e_mem_addr = a.addr; e_mem_we = a.we; e_mem_wdata = i_data_wdata;
        m_busy = 1; m_wait = 0;
        m_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        if (fg || !i_fetch_req) m_streak = 0;
        else if (m_streak < MAXS) m_streak++;
      end else if (comp) begin
        m_busy = 0; e_mem_req = 0; e_mem_we = 0;
      end else if (m_busy) begin
        m_wait++;
      end
      if (o_fetch_valid) begin obs_fv_e = ecount; log_v.push_back(1); end
      if (o_data_valid)  begin obs_dv_e = ecount; log_v.push_back(2); end
    end
    chk1("mem_req", o_mem_req, e_mem_req);
    if (e_mem_req) begin
      chk32("mem_addr", o_mem_addr, e_mem_addr);
      chk1("mem_we", o_mem_we, e_mem_we);
      if (e_mem_we) chk32("mem_wdata", o_mem_wdata, e_mem_wdata);
    end
    chk1("fetch_valid", o_fetch_valid, e_fv);
    chk1("data_valid", o_data_valid, e_dv);
    chk32("fetch_data", o_fetch_data, e_fdata);
    chk32("data_rdata", o_data_rdata, e_drdata);
    chk1("bus_error", o_bus_error, e_err);
    if (fg) begin f_todo--; next_fetch(); end
    if (dg) begin d_todo--; next_data(); end
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    bit done;
    while ((f_todo > 0 || d_todo > 0 || m_busy) && n < budget) begin
      tick(rand_en ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    done = (f_todo == 0) && (d_todo == 0) && !m_busy && !o_mem_req;
    chk1({tag, "_drain"}, done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; i_clk_enable = 1'b0; i_fetch_req = 1'b0; i_data_req = 1'b0;
    i_data_we = 1'b0; i_fetch_addr = '0; i_data_addr = '0; i_data_wdata = '0;
    i_mem_ready = 1'b0; i_mem_rdata = '0;
    f_todo = 0; d_todo = 0; rand_addr = 0; rand_en = 0; lat_mode = 0; ecount = 0;
    model_reset();
    clear_obs();

    // Reset state
    tick(1'b1);
    tick(1'b0);
    rst = 1'b0;
    chk32("rst_mem_addr", o_mem_addr, 32'h0);
    chk32("rst_mem_wdata", o_mem_wdata, 32'h0);
    tick(1'b1);

    // Single fetch, memory answers on the first cycle
    clear_obs(); lat_mode = 0;
    i_fetch_addr = 30'h10; f_todo = 1; i_fetch_req = 1'b1;
    tick(1'b1);
    chk32("s1_mem_addr", o_mem_addr, 32'h40);
    run("s1", 20);
    chk32("s1_grant_to_valid", 32'(obs_fv_e - obs_fg_e), 32'd1);
    chk32("s1_fetch_data", o_fetch_data, 32'h00500093);
    chk1("s1_stall_after", o_stall, 1'b0);

    // Fetch and load together: data first, fetch granted on data's completion
    clear_obs(); lat_mode = 0;
    i_fetch_addr = 30'h123; i_data_addr = 32'h104; i_data_we = 1'b0;
    f_todo = 1; d_todo = 1; i_fetch_req = 1'b1; i_data_req = 1'b1;
    run("s2", 20);
    chk32("s2_first_gnt", 32'(log_g[0]), 32'd2);
    chk32("s2_second_gnt", 32'(log_g[1]), 32'd1);
    chk32("s2_no_bubble", 32'(obs_fg_e), 32'(obs_dv_e));
    chk32("s2_first_valid", 32'(log_v[0]), 32'd2);
    chk32("s2_second_valid", 32'(log_v[1]), 32'd1);

    // Streak limit: both held, fetch forced through after four data grants
    clear_obs(); lat_mode = -1; rand_addr = 1; rand_en = 1;
    f_todo = 1; d_todo = 6; next_fetch(); next_data();
    i_data_we = 1'b0;
    run("s3", 200);
    begin
      int exp3[7] = '{2, 2, 2, 2, 1, 2, 2};
      for (int i = 0; i < 7; i++) chk32("s3_gnt_order", 32'(log_g[i]), 32'(exp3[i]));
    end

    // Store: write strobe and data on the port, zero returned
    clear_obs(); lat_mode = 1; rand_addr = 0; rand_en = 0;
    i_data_we = 1'b1; i_data_addr = 32'h8; i_data_wdata = 32'hDEADBEEF;
    d_todo = 1; i_data_req = 1'b1;
    tick(1'b1);
    chk1("s4_mem_we", o_mem_we, 1'b1);
    chk32("s4_mem_wdata", o_mem_wdata, 32'hDEADBEEF);
    chk32("s4_mem_addr", o_mem_addr, 32'h8);
    run("s4", 20);
    chk32("s4_rdata_zero", o_data_rdata, 32'h0);
    chk32("s4_valid_seen", 32'(log_v.size()), 32'd1);

    // Timeout: memory never answers
    clear_obs(); lat_mode = 255;
    i_data_we = 1'b0; i_data_addr = 32'h200; d_todo = 1; i_data_req = 1'b1;
    run("s5", 40);
    chk32("s5_abort_latency", 32'(obs_dv_e - obs_dg_e), 32'(TMO));
    chk32("s5_rdata_zero", o_data_rdata, 32'h0);
    chk1("s5_bus_error", o_bus_error, 1'b1);

    // Mixed random traffic; bus_error must stay set throughout
    clear_obs(); lat_mode = -1; rand_addr = 1; rand_en = 1;
    f_todo = 12; d_todo = 12; next_fetch(); next_data();
    run("s6", 600);
    chk1("s6_bus_error_sticky", o_bus_error, 1'b1);

    // Reset in the middle of a data access with clk_enable low
    clear_obs(); lat_mode = 255; rand_addr = 0; rand_en = 0;
    i_data_we = 1'b0; i_data_addr = 32'h300; d_todo = 1; i_data_req = 1'b1;
    tick(1'b1); tick(1'b0); tick(1'b1);
    chk1("s7_busy_before_rst", o_mem_req, 1'b1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    chk1("s7_rst_mem_req", o_mem_req, 1'b0);
    chk1("s7_rst_stall", o_stall, 1'b0);
    chk1("s7_rst_bus_error", o_bus_error, 1'b0);
    tick(1'b1); tick(1'b0); tick(1'b1);
    chk32("s7_no_valid", 32'(log_v.size()), 32'd0);
    lat_mode = 0; keep_faddr = 30'h2A5; i_fetch_addr = keep_faddr;
    f_todo = 1; i_fetch_req = 1'b1;
    run("s7", 20);
    chk32("s7_fetch_served", 32'(log_v.size()), 32'd1);
    chk32("s7_fetch_data", o_fetch_data, memfn({keep_faddr, 2'b00}));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single memory port between two requesters: instruction fetch, which is PC-driven, and the s2 data access, which is ALU-address-driven for loads and stores. It replaces the combinational address mux in front of the memory block with a sequenced, variable-latency handshake. Memory may take several enabled cycles per access. The block issues one access at a time, returns read data to the right requester, and asserts a stall toward the control unit while any request is outstanding or waiting. It sits between the control unit/pipeline and the memory block, and is clocked on the same clk/clk_enable scheme as the rest of the core.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced through (1..15)
TIMEOUT_CYCLES, 64, enabled cycles an access may wait for mem_ready before it is aborted (2..255)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
clk_enable  in  1  state advances only on clk edges where this is 1
fetch_req  in  1  fetch request; held until fetch_gnt
fetch_addr  in  30  word address (pc)
fetch_gnt  out  1  fetch request accepted this enabled cycle
fetch_valid  out  1  fetch_data valid
fetch_data  out  32  instruction word
data_req  in  1  load/store request; held until data_gnt
data_we  in  1  1 = store
data_addr  in  32  byte address; bits [1:0] forwarded unchanged
data_wdata  in  32  store data
data_gnt  out  1  data request accepted
data_valid  out  1  data_rdata valid (also pulses for a store completion)
data_rdata  out  32  load data; 0 for stores
mem_req  out  1  access in progress to memory
mem_we  out  1  write strobe
mem_addr  out  32  byte address; fetch = {fetch_addr, 2'b00}
mem_wdata  out  32  write data
mem_ready  in  1  memory completes the access on this enabled cycle
mem_rdata  in  32  read data, valid with mem_ready
stall  out  1  combinational: (fetch_req|data_req) & ~(grant this cycle) | state != IDLE
bus_error  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- States: IDLE, BUSY_FETCH, BUSY_DATA. All transitions happen only on clk edges with clk_enable=1; on other edges every register holds.
- Reset values: state=IDLE. mem_req, mem_we, fetch_valid, data_valid and bus_error are 0. mem_addr, mem_wdata, fetch_data and data_rdata are 0. Streak counter and timeout counter are 0. Reset mid-access drops the access silently: no valid pulse is produced.
- Grant selection happens in IDLE, or in BUSY_* on the completing cycle.
  - Data wins over fetch by default, because the data access belongs to the older instruction.
  - Fetch wins if fetch_req=1 and streak == MAX_DATA_STREAK.
- Grant side effects:
  - Grant is combinational: fetch_gnt/data_gnt are high in the same enabled cycle as the selection.
  - mem_req, mem_addr, mem_we and mem_wdata are registered from the granted request at that edge.
  - The state moves to BUSY_FETCH or BUSY_DATA.
- Streak counter:
  - Increments on a data grant while fetch_req=1.
  - Resets to 0 on any fetch grant, or on a data grant with fetch_req=0.
  - Saturates at MAX_DATA_STREAK.
- Completion (BUSY_*, mem_ready=1):
  - Capture mem_rdata into fetch_data or data_rdata. Stores capture 0.
  - Pulse the matching valid for exactly one enabled cycle; it is held across the intervening non-enabled edge.
  - In the same edge, either issue the next grant (zero-bubble back-to-back) or drop mem_req and return to IDLE.
- Latency: a grant at enabled edge N puts mem_req on the port from N+1. A mem_ready sampled at enabled edge M raises valid from M+1. With memory responding on the first enabled cycle after mem_req, the minimum is 2 enabled cycles from grant to valid.
- Timeout:
  - The counter increments on every enabled cycle in BUSY_* without mem_ready.
  - Reaching TIMEOUT_CYCLES-1 with mem_ready still low aborts the access: valid pulses with data 0, bus_error is set, and the next grant proceeds normally.
  - mem_ready on the same cycle as the limit counts as a normal completion, with no error.
- Requests are not registered until granted. A requester that deasserts req before its grant is simply not served.
- mem_ready arriving while in IDLE is ignored.

Decomposition:
- Package mem_arb_pkg: enum arb_state_t {IDLE, BUSY_FETCH, BUSY_DATA}; typedef for a requester id (FETCH=0, DATA=1); widths WORD_W=32 and PC_W=30.
- One sub-module: arb_priority_sel. It is purely combinational, computing the grant from fetch_req, data_req and the streak counter.

Test Plan:
- Single fetch, fetch_addr=30'h10, mem_ready one enabled cycle after mem_req, mem_rdata=32'h00500093 -> mem_addr=32'h40, fetch_valid pulses 2 enabled cycles after grant, fetch_data=32'h00500093, stall low afterwards.
- fetch_req and data_req raised together (load, addr 32'h104) -> data_gnt first, then fetch_gnt on the completing edge with no IDLE bubble, then data_valid followed by fetch_valid.
- data_req held continuously with fetch_req held, MAX_DATA_STREAK=4 -> 4 data grants, 5th grant goes to fetch, then data resumes.
- Store: data_we=1, data_addr=32'h8, data_wdata=32'hDEADBEEF -> mem_we=1, mem_wdata=32'hDEADBEEF, data_valid pulses, data_rdata=0.
- mem_ready never asserted, TIMEOUT_CYCLES=8 -> after 8 enabled cycles data_valid pulses with data_rdata=0, bus_error=1 and stays 1 until rst.
- rst asserted while in BUSY_DATA with clk_enable toggling -> next edge gives state IDLE, mem_req=0, no valid pulse; a subsequent fetch is served normally.
